// File: rtl/rv_decode_pkg.sv
// -----------------------------------------------------------------------------
// rv_decode_pkg
// Shared RISC-V decode definitions for the decode stage:
//   - supported major opcodes (OP_R, OP_I, OP_LD, OP_S, OP_B)
//   - instruction field bit positions
//   - immediate-format enum and small classification helpers
// No ports (package).
// -----------------------------------------------------------------------------
package rv_decode_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  // Least-significant bit of each instruction field
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef enum logic [1:0] {
    IMM_I    = 2'd0,
    IMM_S    = 2'd1,
    IMM_B    = 2'd2,
    IMM_NONE = 2'd3
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_I, OP_LD: t = IMM_I;
      OP_S:        t = IMM_S;
      OP_B:        t = IMM_B;
      default:     t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic u;
    case (opcode)
      OP_R, OP_S, OP_B, OP_I, OP_LD: u = 1'b1;
      default:                       u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic u;
    case (opcode)
      OP_R, OP_S, OP_B: u = 1'b1;
      default:          u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic is_supported(input logic [6:0] opcode);
    logic s;
    case (opcode)
      OP_R, OP_I, OP_LD, OP_S, OP_B: s = 1'b1;
      default:                       s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator. All immediates are sign-extended from
// inst[31]; opcodes without an I/S/B immediate produce zero.
// Ports:
//   inst  in  32    raw instruction word
//   imm   out XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  imm_type_e imm_type;

  assign imm_type = imm_type_of(inst[OPC_LSB +: 7]);

  // Assemble the immediate according to its format
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// IF/ID + ID/EX pipeline stage. Registers the fetched word, splits it into
// RISC-V fields, builds the immediate, stalls fetch on a load-use hazard
// (issuing a bubble) and flushes both slots on branch_taken.
// Optional feature macro: DECODE_PERF_CNT_EN adds stall/flush counters.
// Ports:
//   clock, reset                 clock, async active-high reset
//   if_valid/if_instruction/if_pc  fetch side
//   id_ready                     stage accepts fetch word this cycle (comb.)
//   branch_taken                 flush request
//   ex_ready                     downstream accepts ID/EX contents
//   ex_mem_read, ex_rd           load in EX and its destination
//   id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
//   id_funct3, id_funct7, id_imm, id_illegal   registered ID/EX outputs
//   stall_cnt, flush_cnt         perf counters (DECODE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
`ifdef DECODE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instruction,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            branch_taken,
  input  logic            ex_ready,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic            id_illegal
`ifdef DECODE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  // IF/ID slot
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            v_f_q, v_f_d;

  // ID/EX slot
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [6:0]      id_opcode_q, id_opcode_d;
  logic [4:0]      id_rd_q, id_rd_d;
  logic [4:0]      id_rs1_q, id_rs1_d;
  logic [4:0]      id_rs2_q, id_rs2_d;
  logic [2:0]      id_funct3_q, id_funct3_d;
  logic [6:0]      id_funct7_q, id_funct7_d;
  logic [XLEN-1:0] id_imm_q, id_imm_d;
  logic            id_illegal_q, id_illegal_d;

  // Decode of the word currently held in IF/ID
  logic [6:0]      dec_opcode;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic            hazard;

  assign dec_opcode = inst_q[OPC_LSB +: 7];
  assign dec_rs1    = inst_q[RS1_LSB +: 5];
  assign dec_rs2    = inst_q[RS2_LSB +: 5];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst_q),
    .imm  (dec_imm)
  );

  // A load writing x0 never produces a value worth waiting for
  assign hazard = v_f_q & ex_mem_read & (ex_rd != 5'd0) &
                  (((ex_rd == dec_rs1) & uses_rs1(dec_opcode)) |
                   ((ex_rd == dec_rs2) & uses_rs2(dec_opcode)));

  // Nothing is accepted while reset is asserted; a flush always frees the slot
  assign id_ready = ~reset & (branch_taken | (ex_ready & ~hazard));

  // Next-state selection: branch flush > downstream stall > load-use bubble > advance
  always_comb begin
    inst_d       = inst_q;
    pc_d         = pc_q;
    v_f_d        = v_f_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_opcode_d  = id_opcode_q;
    id_rd_d      = id_rd_q;
    id_rs1_d     = id_rs1_q;
    id_rs2_d     = id_rs2_q;
    id_funct3_d  = id_funct3_q;
    id_funct7_d  = id_funct7_q;
    id_imm_d     = id_imm_q;
    id_illegal_d = id_illegal_q;
    if (branch_taken) begin
      // Flush: the fetch word presented this cycle is dropped as well
      v_f_d      = 1'b0;
      id_valid_d = 1'b0;
    end else if (!ex_ready) begin
      v_f_d = v_f_q;
    end else if (hazard) begin
      // Bubble into ID/EX; IF/ID keeps the dependent instruction
      id_valid_d   = 1'b0;
      id_pc_d      = '0;
      id_opcode_d  = 7'd0;
      id_rd_d      = 5'd0;
      id_rs1_d     = 5'd0;
      id_rs2_d     = 5'd0;
      id_funct3_d  = 3'd0;
      id_funct7_d  = 7'd0;
      id_imm_d     = '0;
      id_illegal_d = 1'b0;
    end else begin
      id_valid_d   = v_f_q;
      id_pc_d      = pc_q;
      id_opcode_d  = dec_opcode;
      id_rd_d      = inst_q[RD_LSB +: 5];
      id_rs1_d     = dec_rs1;
      id_rs2_d     = dec_rs2;
      id_funct3_d  = inst_q[F3_LSB +: 3];
      id_funct7_d  = inst_q[F7_LSB +: 7];
      id_imm_d     = dec_imm;
      id_illegal_d = v_f_q & ~is_supported(dec_opcode);
      inst_d       = if_instruction;
      pc_d         = if_pc;
      v_f_d        = if_valid;
    end
  end

  // Pipeline registers for both slots
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_q       <= 32'd0;
      pc_q         <= '0;
      v_f_q        <= 1'b0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_opcode_q  <= 7'd0;
      id_rd_q      <= 5'd0;
      id_rs1_q     <= 5'd0;
      id_rs2_q     <= 5'd0;
      id_funct3_q  <= 3'd0;
      id_funct7_q  <= 7'd0;
      id_imm_q     <= '0;
      id_illegal_q <= 1'b0;
    end else begin
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      v_f_q        <= v_f_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_opcode_q  <= id_opcode_d;
      id_rd_q      <= id_rd_d;
      id_rs1_q     <= id_rs1_d;
      id_rs2_q     <= id_rs2_d;
      id_funct3_q  <= id_funct3_d;
      id_funct7_q  <= id_funct7_d;
      id_imm_q     <= id_imm_d;
      id_illegal_q <= id_illegal_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_opcode  = id_opcode_q;
  assign id_rd      = id_rd_q;
  assign id_rs1     = id_rs1_q;
  assign id_rs2     = id_rs2_q;
  assign id_funct3  = id_funct3_q;
  assign id_funct7  = id_funct7_q;
  assign id_imm     = id_imm_q;
  assign id_illegal = id_illegal_q;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally; stalls count only when the bubble is actually issued
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (ex_ready && hazard) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Perf counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
  logic        id_ready;
  logic        branch_taken;
  logic        ex_ready;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [63:0] id_imm;
  logic        id_illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks;
  int failures;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t pend_q[$];   // instruction expected in IF/ID
  fetch_t exp_rec;     // instruction expected in ID/EX
  logic   exp_valid;

  decode_stage #(.XLEN(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .branch_taken   (branch_taken),
    .ex_ready       (ex_ready),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_rd          (id_rd),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_funct3      (id_funct3),
    .id_funct7      (id_funct7),
    .id_imm         (id_imm),
    .id_illegal     (id_illegal)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cnt    (stall_cnt)
    , .flush_cnt    (flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ref_imm(input logic [31:0] i);
    logic [63:0] r;
    case (i[6:0])
      7'b0010011, 7'b0000011: r = {{52{i[31]}}, i[31:20]};
      7'b0100011:             r = {{52{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:             r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default:                r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_illegal(input logic [6:0] op);
    return !(op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011);
  endfunction

  function automatic logic [141:0] ref_fields(input fetch_t f);
    return {f.pc, f.inst[6:0], f.inst[11:7], f.inst[19:15], f.inst[24:20],
            f.inst[14:12], f.inst[31:25], ref_imm(f.inst), ref_illegal(f.inst[6:0])};
  endfunction

  // One clock: drive inputs at the falling edge, check, advance the model
  task automatic step(input logic rst_i, input logic v, input logic [31:0] inst,
                      input logic [63:0] pc, input logic br, input logic exr,
                      input logic mr, input logic [4:0] erd);
    logic   haz;
    logic   rdy;
    logic   u1;
    logic   u2;
    fetch_t f;
    @(negedge clock);
    reset = rst_i; if_valid = v; if_instruction = inst; if_pc = pc;
    branch_taken = br; ex_ready = exr; ex_mem_read = mr; ex_rd = erd;
    #1;
    if (rst_i) begin
      checks++;
      if ({id_valid, id_ready, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
           id_funct3, id_funct7, id_imm, id_illegal} !== 142'd0) begin
        failures++;
        $display("FAIL reset_outputs: valid=%0b ready=%0b pc=%h imm=%h rd=%0d, required all zero",
                 id_valid, id_ready, id_pc, id_imm, id_rd);
      end
      pend_q.delete();
      exp_valid = 1'b0;
    end else begin
      checks++;
      if (id_valid !== exp_valid) begin
        failures++;
        $display("FAIL id_valid @%0t: got %0b required %0b", $time, id_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if ({id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7, id_imm, id_illegal}
            !== ref_fields(exp_rec)) begin
          failures++;
          $display("FAIL id_fields @%0t: got pc=%h rd=%0d imm=%h ill=%0b required pc=%h inst=%h",
                   $time, id_pc, id_rd, id_imm, id_illegal, exp_rec.pc, exp_rec.inst);
        end
      end
      haz = 1'b0;
      if (pend_q.size() > 0) begin
        f   = pend_q[0];
        u1  = (f.inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011});
        u2  = (f.inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011});
        haz = mr && erd != 5'd0 &&
              ((erd == f.inst[19:15] && u1) || (erd == f.inst[24:20] && u2));
      end
      rdy = br || (exr && !haz);
      checks++;
      if (id_ready !== rdy) begin
        failures++;
        $display("FAIL id_ready @%0t: got %0b required %0b", $time, id_ready, rdy);
      end
      if (br) begin
        pend_q.delete();
        exp_valid = 1'b0;
      end else if (!exr) begin
        exp_valid = exp_valid;
      end else if (haz) begin
        exp_valid = 1'b0;
      end else begin
        if (pend_q.size() > 0) begin
          exp_rec   = pend_q.pop_front();
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
        if (v) pend_q.push_back('{pc: pc, inst: inst});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0000_0013, 64'd0, 1'b0, 1'b1, 1'b0, 5'd0);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 32'h0050_0093, 64'd10, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 32'h0050_0093, 64'd10, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 32'h0050_0093, 64'd10, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(2);
    checks++;
    if ({id_valid, id_rd, id_imm, id_pc} !== {1'b1, 5'd1, 64'd5, 64'd10}) begin
      failures++;
      $display("FAIL addi_first: got valid=%0b rd=%0d imm=%0d pc=%0d required 1/1/5/10",
               id_valid, id_rd, id_imm, id_pc);
    end
  endtask

  task automatic test_load_use;
    step(1'b0, 1'b1, 32'h0000_B103, 64'h100, 1'b0, 1'b1, 1'b0, 5'd0); // ld x2,0(x1)
    step(1'b0, 1'b1, 32'h0041_01B3, 64'h104, 1'b0, 1'b1, 1'b0, 5'd0); // add x3,x2,x4
    step(1'b0, 1'b1, 32'h0010_0293, 64'h108, 1'b0, 1'b1, 1'b1, 5'd2); // ld now in EX
    checks++;
    if (id_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_use_ready: got %0b required 0", id_ready);
    end
    step(1'b0, 1'b1, 32'h0010_0293, 64'h108, 1'b0, 1'b1, 1'b0, 5'd0);
    checks++;
    if ({id_valid, id_ready} !== 2'b01) begin
      failures++;
      $display("FAIL load_use_bubble: got valid=%0b ready=%0b required 0/1", id_valid, id_ready);
    end
    idle(1);
    checks++;
    if ({id_valid, id_rd, id_pc} !== {1'b1, 5'd3, 64'h104}) begin
      failures++;
      $display("FAIL load_use_issue: got valid=%0b rd=%0d pc=%h required 1/3/104",
               id_valid, id_rd, id_pc);
    end
    idle(2);
  endtask

  task automatic test_x0_no_stall;
    step(1'b0, 1'b1, 32'h0050_0093, 64'h200, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b0, 32'h0000_0013, 64'd0, 1'b0, 1'b1, 1'b1, 5'd0);
    checks++;
    if (id_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_no_stall: got ready=%0b required 1", id_ready);
    end
    idle(2);
  endtask

  task automatic test_branch_hazard;
    step(1'b0, 1'b1, 32'h0041_01B3, 64'h300, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 32'h0050_0093, 64'h304, 1'b1, 1'b1, 1'b1, 5'd2);
    checks++;
    if (id_ready !== 1'b1) begin
      failures++;
      $display("FAIL branch_hazard_ready: got %0b required 1", id_ready);
    end
    idle(1);
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_flush_valid: got %0b required 0", id_valid);
    end
    idle(2);
  endtask

  task automatic test_back_to_back_stall;
    logic [63:0] frozen_pc;
    step(1'b0, 1'b1, 32'h0010_0093, 64'h400, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 32'h0020_0113, 64'h404, 1'b0, 1'b1, 1'b0, 5'd0);
    frozen_pc = 64'h400;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 32'h0030_0193, 64'h408, 1'b0, 1'b0, 1'b0, 5'd0);
      checks++;
      if ({id_valid, id_pc, id_ready} !== {1'b1, frozen_pc, 1'b0}) begin
        failures++;
        $display("FAIL stall_frozen[%0d]: got valid=%0b pc=%h ready=%0b required 1/%h/0",
                 k, id_valid, id_pc, id_ready, frozen_pc);
      end
    end
    step(1'b0, 1'b1, 32'h0030_0193, 64'h408, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(3);
  endtask

  task automatic test_imm;
    step(1'b0, 1'b1, 32'hFE51_3C23, 64'h500, 1'b0, 1'b1, 1'b0, 5'd0); // sd x5,-8(x2)
    step(1'b0, 1'b1, 32'hFE00_0EE3, 64'h504, 1'b0, 1'b1, 1'b0, 5'd0); // beq x0,x0,-4
    step(1'b0, 1'b1, 32'h1234_50B7, 64'h508, 1'b0, 1'b1, 1'b0, 5'd0); // lui
    checks++;
    if (id_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      failures++;
      $display("FAIL imm_s: got %h required fffffffffffffff8", id_imm);
    end
    idle(1);
    checks++;
    if (id_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL imm_b: got %h required fffffffffffffffc", id_imm);
    end
    idle(1);
    checks++;
    if ({id_valid, id_illegal, id_imm} !== {1'b1, 1'b1, 64'd0}) begin
      failures++;
      $display("FAIL illegal_op: got valid=%0b ill=%0b imm=%h required 1/1/0",
               id_valid, id_illegal, id_imm);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b1, 32'h0010_0093, 64'h600, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 32'h0020_0113, 64'h604, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b0, 32'h0000_0013, 64'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(3);
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_valid = 1'b0; exp_rec = '0;
    reset = 1'b1; if_valid = 1'b0; if_instruction = 32'd0; if_pc = 64'd0;
    branch_taken = 1'b0; ex_ready = 1'b1; ex_mem_read = 1'b0; ex_rd = 5'd0;
    test_reset();
    test_load_use();
    test_x0_no_stall();
    test_branch_hazard();
    test_back_to_back_stall();
    test_imm();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
